speaker_tone_driver: RTL and testbench
======================================

# speaker_tone_driver

Converts the three one-hot speaker-enable levels from the obstacle-warning state machine into audible square-wave tones with a beep cadence, one distinct pitch per direction. Sits between the state-machine outputs and the three speaker pins. Runs a per-beep FSM so that a short enable pulse still produces one complete, audible beep.

## Interface
Parameters:
- TONE_DIV0, default 25000: half-period of the channel-0 tone, in clk cycles; legal range 1..65535.
- TONE_DIV1, default 31250: half-period of the channel-1 tone, in clk cycles; legal range 1..65535.
- TONE_DIV2, default 41667: half-period of the channel-2 tone, in clk cycles; legal range 1..65535.
- BEEP_ON_CYC, default 5000000: length of the tone burst, in clk cycles; legal range 1..2^24-1.
- BEEP_OFF_CYC, default 2500000: length of the silent gap, in clk cycles; legal range 1..2^24-1.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- ena, in, 1: global enable. When low, all state and counters freeze and outputs hold their values.
- spk_en, in, 3: speaker enable levels. Bit 0 has the highest priority.
- tone_out, out, 3: square-wave drive, one bit per speaker.
- active, out, 3: one-hot index of the channel currently latched. All zeros in IDLE.
- busy, out, 1: high whenever state is not IDLE.

## Operation
- Reset (rst_n low at a clk edge while ena is high):
  - state goes to IDLE.
  - tone_out, active, busy and all counters go to 0.
- Selection:
  - The selected channel is the lowest set bit of spk_en.
  - The selection is latched into ch only on entry to BEEP_ON.
  - ch is held constant for the whole beep.
- IDLE: if spk_en is nonzero, latch ch, load cad_cnt with BEEP_ON_CYC-1, load div_cnt with TONE_DIV[ch]-1, set tone_out[ch]=1, and go to BEEP_ON.
- BEEP_ON:
  - div_cnt decrements every cycle. When it reaches 0, tone_out[ch] toggles and div_cnt reloads.
  - cad_cnt decrements every cycle. When it reaches 0, tone_out goes to 0, cad_cnt loads BEEP_OFF_CYC-1, and the FSM goes to BEEP_OFF.
  - Changes on spk_en, including deassertion or a higher-priority bit, are ignored until the beep ends.
- BEEP_OFF: tone_out stays 0. When cad_cnt reaches 0:
  - If spk_en is nonzero, re-select, re-latch ch, and enter BEEP_ON as described from IDLE.
  - Otherwise go to IDLE and clear active.
- Only tone_out[ch] ever toggles. The other two bits stay 0 at all times.
- A multi-hot spk_en (not produced upstream) resolves by priority. It is not an error.
- Reset asserted mid-beep aborts immediately. No tail is played.

## Timing
- Latency: spk_en is sampled nonzero at edge N while in IDLE. At edge N, tone_out[ch]=1, active is valid and busy=1.
- Tone shape:
  - Each tone_out half-period lasts exactly TONE_DIV[ch] cycles.
  - The first half-period starts high.
  - When BEEP_ON_CYC is not a multiple of TONE_DIV, the last half-period is truncated.
- Burst lengths:
  - The burst lasts exactly BEEP_ON_CYC cycles.
  - The gap lasts exactly BEEP_OFF_CYC cycles.
  - The beep period is BEEP_ON_CYC+BEEP_OFF_CYC.
- Gap-end decision: the decision is made on the same edge at which cad_cnt reaches 0 in BEEP_OFF. No extra IDLE cycle is inserted between back-to-back beeps.
- Enable freeze: when ena is low for K cycles, every duration is stretched by exactly K cycles.
- Counter widths: div_cnt is 16 bits and cad_cnt is 24 bits. A parameter value of 1 means a reload value of 0, which toggles or advances every cycle.

## Configuration
- BEEP_CADENCE_EN defined:
  - The behaviour is as described above.
- BEEP_CADENCE_EN not defined:
  - BEEP_OFF is not compiled and BEEP_OFF_CYC is ignored.
  - When a burst ends, spk_en is evaluated on the same edge:
    - If spk_en is nonzero, the FSM reloads and re-enters BEEP_ON directly. The tone restarts high with no gap, and the channel may change at this point.
    - If spk_en is zero, the FSM goes to IDLE with tone_out=0.

## Structure
- Shared package speaker_pkg holds:
  - the state enum (IDLE, BEEP_ON, BEEP_OFF);
  - the 2-bit channel index type;
  - DIV_W=16 and CAD_W=24;
  - the default divider and cadence constants;
  - a priority-select function that maps a 3-bit enable vector to a channel index.
- One sub-module, tone_divider, holds:
  - the loadable 16-bit down-counter and the toggle flop;
  - a load and divisor input;
  - a run enable;
  - a single square output.
- The top level routes the tone_divider output to tone_out[ch].

## Test plan
All scenarios use TONE_DIV0=2, TONE_DIV1=3, TONE_DIV2=4, BEEP_ON_CYC=12, BEEP_OFF_CYC=8.

- **Reset:** hold rst_n=0 for 3 cycles with spk_en=111 → tone_out=000, active=000, busy=0 throughout.
- **Single pulse:** assert spk_en=001 for 1 cycle, then 000 → tone_out[0] runs 1100 1100 1100 over 12 cycles, then 0 for 8 cycles, then IDLE with busy=0.
- **Held enable:** hold spk_en=100 → repeated bursts of tone_out[2] (4 high, 4 low, 4 high), each followed by an 8-cycle gap. Period is 20 cycles with no idle cycle between beeps.
- **Preemption timing:** spk_en=010, then 011 during BEEP_ON → channel 1 finishes its 12-cycle burst and 8-cycle gap. The next burst is on channel 0 and active=001.
- **Freeze and abort:** drop ena low for 5 cycles mid-burst → the burst lasts 17 wall cycles. Then assert rst_n=0 mid-burst → outputs are 0 on the next edge.
- **Without BEEP_CADENCE_EN:** hold spk_en=001 → continuous tone_out[0] period-4 square with no gap. Dropping spk_en ends the tone at the next 12-cycle boundary.

Source files
------------

// File: rtl/speaker_pkg.sv
// Shared types, widths and defaults for the speaker tone driver.
package speaker_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP_ON  = 2'd1,
        BEEP_OFF = 2'd2
    } state_e;

    typedef logic [1:0] ch_t;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned CAD_W = 24;

    localparam int unsigned TONE_DIV0_DEF    = 25000;
    localparam int unsigned TONE_DIV1_DEF    = 31250;
    localparam int unsigned TONE_DIV2_DEF    = 41667;
    localparam int unsigned BEEP_ON_CYC_DEF  = 5000000;
    localparam int unsigned BEEP_OFF_CYC_DEF = 2500000;

    // Lowest set bit wins; an all-zero vector maps to channel 2 but is never latched.
    function automatic ch_t prio_sel(input logic [2:0] en);
        if (en[0]) begin
            return 2'd0;
        end else if (en[1]) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

    function automatic logic [2:0] ch_onehot(input ch_t ch);
        logic [2:0] base;
        base = 3'b001;
        return base << ch;
    endfunction

endpackage

// File: rtl/speaker_tone_driver_divider.sv
// Loadable half-period down-counter with toggle flop; output starts high on load.
module tone_divider
    import speaker_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             sq_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sq_q, sq_d;
    logic [DIV_W-1:0] reload_c;

    assign reload_c = div_i - DIV_W'(1);

    // Square output is forced low whenever the burst is not running.
    always_comb begin
        cnt_d = cnt_q;
        sq_d  = sq_q;
        if (load_i) begin
            cnt_d = reload_c;
            sq_d  = 1'b1;
        end else if (run_i) begin
            if (cnt_q == '0) begin
                cnt_d = reload_c;
                sq_d  = ~sq_q;
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end else begin
            sq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            if (!rst_n) begin
                cnt_q <= '0;
                sq_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                sq_q  <= sq_d;
            end
        end
    end

    assign sq_o = sq_q;

endmodule

// File: rtl/speaker_tone_driver.sv
// Beep-cadence tone generator for three prioritised speaker enables.
// Define BEEP_CADENCE_EN to insert the silent BEEP_OFF gap between bursts.
module speaker_tone_driver
    import speaker_pkg::*;
#(
    parameter int unsigned TONE_DIV0    = TONE_DIV0_DEF,
    parameter int unsigned TONE_DIV1    = TONE_DIV1_DEF,
    parameter int unsigned TONE_DIV2    = TONE_DIV2_DEF,
    parameter int unsigned BEEP_ON_CYC  = BEEP_ON_CYC_DEF,
    parameter int unsigned BEEP_OFF_CYC = BEEP_OFF_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] spk_en,
    output logic [2:0] tone_out,
    output logic [2:0] active,
    output logic       busy
);

    if (TONE_DIV0 < 1 || TONE_DIV0 > 65535 || TONE_DIV1 < 1 || TONE_DIV1 > 65535 ||
        TONE_DIV2 < 1 || TONE_DIV2 > 65535 || BEEP_ON_CYC < 1 || BEEP_ON_CYC > 16777215 ||
        BEEP_OFF_CYC < 1 || BEEP_OFF_CYC > 16777215) begin : g_param_chk
        $error("speaker_tone_driver: parameter out of legal range");
    end

    localparam logic [DIV_W-1:0] DIV0      = DIV_W'(TONE_DIV0);
    localparam logic [DIV_W-1:0] DIV1      = DIV_W'(TONE_DIV1);
    localparam logic [DIV_W-1:0] DIV2      = DIV_W'(TONE_DIV2);
    localparam logic [CAD_W-1:0] ON_RELOAD = CAD_W'(BEEP_ON_CYC - 1);
`ifdef BEEP_CADENCE_EN
    localparam logic [CAD_W-1:0] OFF_RELOAD = CAD_W'(BEEP_OFF_CYC - 1);
`endif

    state_e           state_q, state_d;
    logic [CAD_W-1:0] cad_q, cad_d;
    ch_t              ch_q, ch_d;
    logic [2:0]       active_q, active_d;
    logic             busy_q, busy_d;
    logic             start_c, idle_c, run_c;
    ch_t              sel_c, div_ch_c;
    logic [DIV_W-1:0] div_c;
    logic             sq;

    assign sel_c = prio_sel(spk_en);

    // Next-state: start_c/idle_c collect the shared burst-start and return-to-idle actions.
    always_comb begin
        state_d  = state_q;
        cad_d    = cad_q;
        ch_d     = ch_q;
        active_d = active_q;
        busy_d   = busy_q;
        start_c  = 1'b0;
        idle_c   = 1'b0;
        run_c    = 1'b0;
        case (state_q)
            IDLE: begin
                start_c = |spk_en;
            end
            BEEP_ON: begin
                if (cad_q != '0) begin
                    cad_d = cad_q - CAD_W'(1);
                    run_c = 1'b1;
                end else begin
`ifdef BEEP_CADENCE_EN
                    state_d = BEEP_OFF;
                    cad_d   = OFF_RELOAD;
`else
                    start_c = |spk_en;
                    idle_c  = ~|spk_en;
`endif
                end
            end
`ifdef BEEP_CADENCE_EN
            BEEP_OFF: begin
                if (cad_q != '0) begin
                    cad_d = cad_q - CAD_W'(1);
                end else begin
                    start_c = |spk_en;
                    idle_c  = ~|spk_en;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        if (start_c) begin
            state_d  = BEEP_ON;
            ch_d     = sel_c;
            active_d = ch_onehot(sel_c);
            busy_d   = 1'b1;
            cad_d    = ON_RELOAD;
        end else if (idle_c) begin
            state_d  = IDLE;
            active_d = '0;
            busy_d   = 1'b0;
        end
    end

    // The divider loads the newly selected channel's pitch on burst start.
    assign div_ch_c = start_c ? sel_c : ch_q;

    always_comb begin
        case (div_ch_c)
            2'd0:    div_c = DIV0;
            2'd1:    div_c = DIV1;
            default: div_c = DIV2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            if (!rst_n) begin
                state_q  <= IDLE;
                cad_q    <= '0;
                ch_q     <= 2'd0;
                active_q <= '0;
                busy_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cad_q    <= cad_d;
                ch_q     <= ch_d;
                active_q <= active_d;
                busy_q   <= busy_d;
            end
        end
    end

    tone_divider u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .load_i (start_c),
        .run_i  (run_c),
        .div_i  (div_c),
        .sq_o   (sq)
    );

    assign tone_out = active_q & {3{sq}};
    assign active   = active_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_speaker_tone_driver.sv
// Directed bench for speaker_tone_driver; covers both BEEP_CADENCE_EN builds.
module tb_speaker_tone_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [2:0] spk_en;
    logic [2:0] tone_out;
    logic [2:0] active;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Expected burst waveforms, cycle 0 in the MSB (half-periods 2, 3, 4 over 12 cycles).
    logic [11:0] pat0 = 12'b110011001100;
    logic [11:0] pat1 = 12'b111000111000;
    logic [11:0] pat2 = 12'b111100001111;

    logic [6:0] got;
    logic [6:0] exp;

    speaker_tone_driver #(
        .TONE_DIV0    (2),
        .TONE_DIV1    (3),
        .TONE_DIV2    (4),
        .BEEP_ON_CYC  (12),
        .BEEP_OFF_CYC (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .spk_en   (spk_en),
        .tone_out (tone_out),
        .active   (active),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        spk_en = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {tone_out, active, busy};
            total++;
            if (got !== 7'b0) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", i, got, 7'b0);
            end
        end
        rst_n  = 1'b1;
        spk_en = 3'b000;
        @(negedge clk);
        got = {tone_out, active, busy};
        total++;
        if (got !== 7'b0) begin
            bad++;
            $display("FAIL reset_release got=%b exp=%b", got, 7'b0);
        end
    endtask

    task automatic test_single();
        spk_en = 3'b001;
        @(negedge clk);
        spk_en = 3'b000;
        for (int k = 0; k < 12; k++) begin
            got = {tone_out, active, busy};
            exp = {2'b00, pat0[11-k], 3'b001, 1'b1};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL single_burst t=%0d got=%b exp=%b", k, got, exp);
            end
            @(negedge clk);
        end
`ifdef BEEP_CADENCE_EN
        for (int k = 0; k < 8; k++) begin
            got = {tone_out, active, busy};
            exp = {3'b000, 3'b001, 1'b1};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL single_gap t=%0d got=%b exp=%b", k, got, exp);
            end
            @(negedge clk);
        end
`endif
        got = {tone_out, active, busy};
        total++;
        if (got !== 7'b0) begin
            bad++;
            $display("FAIL single_idle got=%b exp=%b", got, 7'b0);
        end
    endtask

    task automatic test_held();
`ifdef BEEP_CADENCE_EN
        spk_en = 3'b100;
        @(negedge clk);
        for (int t = 0; t < 40; t++) begin
            int b;
            b = t % 20;
            got = {tone_out, active, busy};
            if (b < 12) exp = {pat2[11-b], 2'b00, 3'b100, 1'b1};
            else        exp = {3'b000, 3'b100, 1'b1};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL held t=%0d got=%b exp=%b", t, got, exp);
            end
            if (t == 39) spk_en = 3'b000;
            @(negedge clk);
        end
`else
        spk_en = 3'b001;
        @(negedge clk);
        for (int t = 0; t < 36; t++) begin
            got = {tone_out, active, busy};
            exp = {2'b00, ((t % 4) < 2), 3'b001, 1'b1};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL held t=%0d got=%b exp=%b", t, got, exp);
            end
            if (t == 29) spk_en = 3'b000;
            @(negedge clk);
        end
`endif
        got = {tone_out, active, busy};
        total++;
        if (got !== 7'b0) begin
            bad++;
            $display("FAIL held_end got=%b exp=%b", got, 7'b0);
        end
    endtask

    task automatic test_preempt();
        int last;
`ifdef BEEP_CADENCE_EN
        last = 20;
`else
        last = 12;
`endif
        spk_en = 3'b010;
        @(negedge clk);
        for (int t = 0; t <= last; t++) begin
            got = {tone_out, active, busy};
            if (t < 12)        exp = {1'b0, pat1[11-t], 1'b0, 3'b010, 1'b1};
            else if (t < last) exp = {3'b000, 3'b010, 1'b1};
            else               exp = {3'b001, 3'b001, 1'b1};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL preempt t=%0d got=%b exp=%b", t, got, exp);
            end
            if (t == 3) spk_en = 3'b011;
            if (t < last) @(negedge clk);
        end
        spk_en = 3'b000;
        for (int i = 0; i < 40 && busy !== 1'b0; i++) @(negedge clk);
        got = {tone_out, active, busy};
        total++;
        if (got !== 7'b0) begin
            bad++;
            $display("FAIL preempt_idle got=%b exp=%b", got, 7'b0);
        end
    endtask

    task automatic test_freeze_abort();
        int  b;
        logic ena_next;
        spk_en = 3'b001;
        @(negedge clk);
        spk_en = 3'b000;
        b = 0;
        for (int w = 0; w < 17; w++) begin
            got = {tone_out, active, busy};
            exp = {2'b00, pat0[11-b], 3'b001, 1'b1};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL freeze w=%0d got=%b exp=%b", w, got, exp);
            end
            ena_next = !(w >= 4 && w <= 8);
            ena = ena_next;
            if (ena_next) b++;
            @(negedge clk);
        end
        total++;
`ifdef BEEP_CADENCE_EN
        exp = {3'b000, 3'b001, 1'b1};
`else
        exp = 7'b0;
`endif
        got = {tone_out, active, busy};
        if (got !== exp) begin
            bad++;
            $display("FAIL freeze_end got=%b exp=%b", got, exp);
        end
        for (int i = 0; i < 40 && busy !== 1'b0; i++) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL freeze_idle busy=%b exp=0", busy);
        end

        // Multi-hot start resolves to channel 1, then reset aborts mid-burst.
        spk_en = 3'b110;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            got = {tone_out, active, busy};
            exp = {3'b010, 3'b010, 1'b1};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL abort_burst t=%0d got=%b exp=%b", t, got, exp);
            end
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {tone_out, active, busy};
            total++;
            if (got !== 7'b0) begin
                bad++;
                $display("FAIL abort_reset cyc=%0d got=%b exp=%b", i, got, 7'b0);
            end
        end
        rst_n  = 1'b1;
        spk_en = 3'b000;
        @(negedge clk);
        got = {tone_out, active, busy};
        total++;
        if (got !== 7'b0) begin
            bad++;
            $display("FAIL abort_release got=%b exp=%b", got, 7'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held();
        test_preempt();
        test_freeze_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
